// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: denomination coding, coin values and
// the change dispenser state encoding.
package vm_pkg;

   localparam int NUM_DENOM = 5;

   localparam logic [2:0] D5   = 3'd0;
   localparam logic [2:0] D10  = 3'd1;
   localparam logic [2:0] D20  = 3'd2;
   localparam logic [2:0] D50  = 3'd3;
   localparam logic [2:0] D100 = 3'd4;

   localparam int unsigned DENOM_VALUE [NUM_DENOM] = '{5, 10, 20, 50, 100};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_WAIT_ACK,
      ST_DONE
   } state_t;

   // Case decode keeps out-of-range indices harmless (value 0).
   function automatic logic [6:0] denom_value(input logic [2:0] d);
      case (d)
         D5:      denom_value = 7'd5;
         D10:     denom_value = 7'd10;
         D20:     denom_value = 7'd20;
         D50:     denom_value = 7'd50;
         D100:    denom_value = 7'd100;
         default: denom_value = 7'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_denom_select.sv
// Greedy coin picker: highest denomination that fits the remaining amount,
// has stock and whose hopper is not faulted.
module change_denom_select
   import vm_pkg::*;
#(
   parameter int AMT_W = 10
) (
   input  logic [AMT_W-1:0] remaining,
   input  logic [4:0]       inv_nz,
   input  logic [4:0]       fault,
   output logic             found,
   output logic [2:0]       denom
);

   // Ascending scan, so the last hit is the highest eligible denomination.
   always_comb begin
      found = 1'b0;
      denom = D5;
      for (int i = 0; i < NUM_DENOM; i++) begin
         if (inv_nz[i] && !fault[i] && (32'(remaining) >= DENOM_VALUE[i])) begin
            found = 1'b1;
            denom = 3'(i);
         end
      end
   end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser: greedy coin decomposition, one-coin-at-a-time hopper
// sequencing with ack timeout, inventory and sticky hopper fault tracking.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request; refills accepted
// SELECT   | pick next coin denomination or finish
// EJECT    | eject pulse for the chosen hopper, timer cleared
// WAIT_ACK | wait for coin-drop ack, fault hopper after TIMEOUT cycles
// DONE     | done pulse, report shortfall and residual
module change_dispenser_ctrl
   import vm_pkg::*;
#(
   parameter int AMT_W   = 10,
   parameter int CNT_W   = 6,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             refill_valid,
   input  logic [2:0]       refill_denom,
   input  logic [CNT_W-1:0] refill_qty,
   output logic [4:0]       eject,
   input  logic             eject_ack,
   output logic             done,
   output logic             done_short,
   output logic [AMT_W-1:0] residual,
   output logic [CNT_W-1:0] inv_5,
   output logic [CNT_W-1:0] inv_10,
   output logic [CNT_W-1:0] inv_20,
   output logic [CNT_W-1:0] inv_50,
   output logic [CNT_W-1:0] inv_100,
   output logic [4:0]       hopper_fault
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [AMT_W-1:0] remaining;
   logic [2:0]       cur_d;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] inv [NUM_DENOM];
   logic [4:0]       inv_nz;

   logic             sel_found;
   logic [2:0]       sel_d;
   logic [4:0]       eject_nxt;
   logic             done_nxt;
   logic             accept;
   logic             ack_take;
   logic             tmo;
   logic             timer_clr;
   logic             timer_inc;
   logic             refill_hit;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      sat_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_DENOM; i++) inv_nz[i] = |inv[i];
   end

   change_denom_select #(.AMT_W(AMT_W)) u_select (
      .remaining (remaining),
      .inv_nz    (inv_nz),
      .fault     (hopper_fault),
      .found     (sel_found),
      .denom     (sel_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      eject_nxt = '0;
      done_nxt  = 1'b0;
      accept    = 1'b0;
      ack_take  = 1'b0;
      tmo       = 1'b0;
      timer_clr = 1'b0;
      timer_inc = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (sel_found) begin
               eject_nxt = 5'd1 << sel_d;
               state_nxt = ST_EJECT;
            end else begin
               done_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_EJECT: begin
            timer_clr = 1'b1;
            state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (eject_ack) begin
               ack_take  = 1'b1;
               state_nxt = ST_SELECT;
            end else if (timer == TMR_TERM) begin
               tmo       = 1'b1;
               state_nxt = ST_SELECT;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign req_ready  = (state == ST_IDLE);
   assign refill_hit = req_ready && refill_valid && (refill_denom < 3'd5);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remaining    <= '0;
         cur_d        <= D5;
         timer        <= '0;
         eject        <= '0;
         done         <= 1'b0;
         done_short   <= 1'b0;
         residual     <= '0;
         hopper_fault <= '0;
         for (int i = 0; i < NUM_DENOM; i++) inv[i] <= '0;
      end else begin
         eject      <= eject_nxt;
         done       <= done_nxt;
         done_short <= done_nxt && (remaining != '0);
         if (done_nxt) residual <= remaining;

         if (accept)                 remaining <= req_amount;
         else if (ack_take)          remaining <= remaining - AMT_W'(denom_value(cur_d));
         if (state == ST_SELECT)     cur_d     <= sel_d;

         if (timer_clr)      timer <= '0;
         else if (timer_inc) timer <= timer + 1'b1;

         for (int i = 0; i < NUM_DENOM; i++) begin
            if (refill_hit && refill_denom == 3'(i)) begin
               inv[i]          <= sat_add(inv[i], refill_qty);
               hopper_fault[i] <= 1'b0;
            end
            if (ack_take && cur_d == 3'(i)) inv[i] <= inv[i] - 1'b1;
            if (tmo && cur_d == 3'(i))      hopper_fault[i] <= 1'b1;
         end
      end
   end

   assign inv_5   = inv[0];
   assign inv_10  = inv[1];
   assign inv_20  = inv[2];
   assign inv_50  = inv[3];
   assign inv_100 = inv[4];

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed bench for change_dispenser_ctrl: greedy order, latency, shortfall,
// hopper timeout, refill saturation/gating and asynchronous reset.
module tb_change_dispenser_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [9:0] req_amount;
   logic       req_ready;
   logic       refill_valid;
   logic [2:0] refill_denom;
   logic [5:0] refill_qty;
   logic [4:0] eject;
   logic       eject_ack;
   logic       done;
   logic       done_short;
   logic [9:0] residual;
   logic [5:0] inv_5, inv_10, inv_20, inv_50, inv_100;
   logic [4:0] hopper_fault;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   int         done_cyc;
   logic       got_short;
   logic [9:0] got_res;
   logic [4:0] ej_q[$];
   bit         done_seen;

   always #5 clk = ~clk;

   change_dispenser_ctrl #(.AMT_W(10), .CNT_W(6), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_amount   (req_amount),
      .req_ready    (req_ready),
      .refill_valid (refill_valid),
      .refill_denom (refill_denom),
      .refill_qty   (refill_qty),
      .eject        (eject),
      .eject_ack    (eject_ack),
      .done         (done),
      .done_short   (done_short),
      .residual     (residual),
      .inv_5        (inv_5),
      .inv_10       (inv_10),
      .inv_20       (inv_20),
      .inv_50       (inv_50),
      .inv_100      (inv_100),
      .hopper_fault (hopper_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic refill(input logic [2:0] d, input logic [5:0] q);
      @(negedge clk);
      refill_valid = 1'b1;
      refill_denom = d;
      refill_qty   = q;
      @(negedge clk);
      refill_valid = 1'b0;
   endtask

   // Accept in cycle 0; cycle c is observed mid-cycle at the c-th negedge after.
   task automatic run_req(input int amount, input bit auto_ack);
      logic [4:0] last_ej;
      last_ej  = '0;
      done_cyc = -1;
      ej_q.delete();
      @(negedge clk);
      req_valid  = 1'b1;
      req_amount = 10'(amount);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         eject_ack = auto_ack && (last_ej != 5'd0);
         last_ej   = eject;
         if (eject != 5'd0) ej_q.push_back(eject);
         if (done) begin
            done_cyc  = c;
            got_short = done_short;
            got_res   = residual;
            break;
         end
      end
      eject_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_amount = '0;
      refill_valid = 1'b0; refill_denom = '0; refill_qty = '0; eject_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      check("rst_ready", req_ready, 1);
      check("rst_eject", eject, 0);
      check("rst_done", {done, done_short}, 0);
      check("rst_residual", residual, 0);
      check("rst_inv", {inv_5, inv_10, inv_20, inv_50, inv_100}, 0);
      check("rst_fault", hopper_fault, 0);

      // Full set: 185 = 100+50+20+10+5
      for (int d = 0; d < 5; d++) refill(3'(d), 6'd5);
      run_req(185, 1'b1);
      check("full_done_cyc", done_cyc, 17);
      check("full_n_ej", ej_q.size(), 5);
      if (ej_q.size() == 5) begin
         check("full_ej0", ej_q[0], 5'b10000);
         check("full_ej1", ej_q[1], 5'b01000);
         check("full_ej2", ej_q[2], 5'b00100);
         check("full_ej3", ej_q[3], 5'b00010);
         check("full_ej4", ej_q[4], 5'b00001);
      end
      check("full_short", got_short, 0);
      check("full_res", got_res, 0);
      check("full_inv", {inv_5, inv_10, inv_20, inv_50, inv_100}, {6'd4, 6'd4, 6'd4, 6'd4, 6'd4});
      @(negedge clk);
      check("full_ready_after", req_ready, 1);
      check("full_done_pulse", done, 0);

      // Greedy shortfall: 60 with one 50 and three 20s
      do_reset();
      refill(3'd3, 6'd1);
      refill(3'd2, 6'd3);
      run_req(60, 1'b1);
      check("greedy_done_cyc", done_cyc, 5);
      check("greedy_n_ej", ej_q.size(), 1);
      if (ej_q.size() == 1) check("greedy_ej0", ej_q[0], 5'b01000);
      check("greedy_short", got_short, 1);
      check("greedy_res", got_res, 10);
      check("greedy_inv20", inv_20, 3);
      check("greedy_inv50", inv_50, 0);

      // Hopper timeout: 2 SELECT/EJECT cycles, 15 WAIT_ACK, SELECT, DONE
      do_reset();
      refill(3'd4, 6'd2);
      run_req(100, 1'b0);
      check("tmo_done_cyc", done_cyc, 19);
      check("tmo_n_ej", ej_q.size(), 1);
      check("tmo_fault", hopper_fault, 5'b10000);
      check("tmo_inv100", inv_100, 2);
      check("tmo_short", got_short, 1);
      check("tmo_res", got_res, 100);
      refill(3'd4, 6'd0);
      check("tmo_fault_clr", hopper_fault, 0);
      check("tmo_inv100_kept", inv_100, 2);

      // Non-multiple of 5
      do_reset();
      refill(3'd0, 6'd3);
      run_req(7, 1'b1);
      check("nm5_n_ej", ej_q.size(), 1);
      check("nm5_short", got_short, 1);
      check("nm5_res", got_res, 2);
      check("nm5_inv5", inv_5, 2);

      // Zero amount
      run_req(0, 1'b1);
      check("zero_done_cyc", done_cyc, 2);
      check("zero_short", got_short, 0);
      check("zero_res", got_res, 0);

      // Saturation and ignored out-of-range refill
      do_reset();
      refill(3'd1, 6'd60);
      refill(3'd1, 6'd10);
      check("sat_inv10", inv_10, 63);
      refill(3'd6, 6'd7);
      check("bad_denom", {inv_5, inv_20, inv_50, inv_100}, 0);

      // Refill and early ack during EJECT are ignored
      @(negedge clk);
      req_valid = 1'b1; req_amount = 10'd10;
      @(negedge clk);
      req_valid = 1'b0;
      check("busy_ready", req_ready, 0);
      @(negedge clk);
      check("gate_eject", eject, 5'b00010);
      refill_valid = 1'b1; refill_denom = 3'd0; refill_qty = 6'd5;
      eject_ack = 1'b1;
      @(negedge clk);
      refill_valid = 1'b0; eject_ack = 1'b0;
      check("gate_refill", inv_5, 0);
      check("gate_early_ack", inv_10, 63);
      @(negedge clk);
      eject_ack = 1'b1;
      @(negedge clk);
      eject_ack = 1'b0;
      check("gate_ack_inv10", inv_10, 62);
      @(negedge clk);
      check("gate_done", {done, done_short}, 2'b10);

      // Asynchronous reset in WAIT_ACK
      do_reset();
      refill(3'd4, 6'd2);
      @(negedge clk);
      req_valid = 1'b1; req_amount = 10'd100;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_eject", eject, 0);
      check("arst_ready", req_ready, 1);
      check("arst_inv", {inv_5, inv_10, inv_20, inv_50, inv_100}, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      done_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      check("arst_no_done", done_seen, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/change_dispenser_ctrl.md
# change_dispenser_ctrl

Change dispenser controller for the vending machine. It accepts a change amount from the vending FSM and decomposes it greedily into 100/50/20/10/5 coins, limited by per-denomination inventory. It sequences the coin hoppers one coin at a time over an eject/ack handshake and maintains inventory and hopper-fault state. It sits between the vending FSM's give-change path and the physical hopper drivers.

## Interface
- `AMT_W`, default 10: change amount width; maximum request is 1023.
- `CNT_W`, default 6: inventory counter width per denomination; saturates at 2^CNT_W-1.
- `TIMEOUT`, default 15: maximum number of WAIT_ACK cycles before a hopper is declared faulted.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-low**.
- `req_valid` in 1: change request valid.
- `req_amount` in AMT_W: change amount in rupees.
- `req_ready` out 1: high only in IDLE.
- `refill_valid` in 1: hopper refill strobe.
- `refill_denom` in 3: denomination index (0=5, 1=10, 2=20, 3=50, 4=100). Values 5-7 are ignored.
- `refill_qty` in CNT_W: number of coins added.
- `eject` out 5: one-hot, single-cycle pulse; bit i ejects one coin of denomination i.
- `eject_ack` in 1: the hopper confirms that a coin dropped.
- `done` out 1: single-cycle pulse at the end of a request.
- `done_short` out 1: valid with `done`; the full amount was not paid.
- `residual` out AMT_W: unpaid amount. Updated at `done` and held until the next accept.
- `inv_5`, `inv_10`, `inv_20`, `inv_50`, `inv_100` out CNT_W each: current coin inventory.
- `hopper_fault` out 5: sticky fault flag per denomination.

## Operation
- **States:** IDLE, SELECT, EJECT, WAIT_ACK, DONE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch `remaining`=`req_amount` and go to SELECT.
  - A refill in IDLE adds `refill_qty` to the selected inventory with saturation and clears that denomination's fault bit.
  - If refill and request occur in the same cycle, both are taken. The refill is visible in the first SELECT.
  - Refills outside IDLE are ignored.
- **SELECT:**
  - Pick the highest denomination d with value(d) ≤ `remaining`, inventory(d) > 0 and `hopper_fault`[d]=0.
  - If d is found, go to EJECT. Otherwise go to DONE.
  - Selection is greedy only; no backtracking. A shortfall is reported even when a non-greedy solution exists.
- **EJECT:** assert `eject`[d] for one cycle, clear the timer, go to WAIT_ACK.
- **WAIT_ACK:**
  - `eject_ack` is sampled only in this state; an ack in any other state is ignored.
  - On ack: inventory(d) -= 1, `remaining` -= value(d), go to SELECT.
  - If TIMEOUT cycles pass with no ack: set `hopper_fault`[d], leave inventory and `remaining` unchanged, go to SELECT.
- **DONE:**
  - `done`=1.
  - `done_short`=(`remaining`≠0).
  - `residual`=`remaining`.
  - Go to IDLE.
- **Arithmetic:**
  - `remaining` never underflows, because value(d) ≤ `remaining` is guaranteed at selection.
  - Amounts that are not a multiple of 5 always finish short, with residual = amount mod 5 or more.
- **Zero amount:** a request of 0 goes IDLE→SELECT→DONE with `done_short`=0.

## Timing
- **Reset values:**
  - State IDLE, `req_ready`=1.
  - `eject`=0, `done`=0, `done_short`=0, `residual`=0.
  - All inventories 0, `hopper_fault`=0, timer 0.
- **Reset mid-operation:**
  - Abort immediately, with no `done` pulse.
  - Inventory is cleared, including coins already dispensed for the aborted request.
- **Latency (accept at cycle 0, k coins, ack in the first WAIT_ACK cycle):** `done` is asserted in cycle 3k+2. Each coin costs at least 3 cycles (SELECT, EJECT, WAIT_ACK).
- **Timeout path:** WAIT_ACK lasts exactly TIMEOUT cycles. The fault bit is visible in the next SELECT cycle.
- **Outputs:**
  - `eject` and `done` are registered pulses.
  - `req_ready` is decoded from state.
  - `inv_*` update on the clock edge that consumes the ack or refill.

## Structure
- **Package `vm_pkg`:**
  - Denomination index constants (D5..D100).
  - `DENOM_VALUE` array {5,10,20,50,100}.
  - State enum.
  - Shared with the vending FSM for consistent denomination coding.
- **Sub-module `change_denom_select`:** combinational priority picker. Inputs are `remaining`, the inventory-nonzero vector and the fault vector. Outputs are a found flag and index d.
- **Top level:** holds the FSM, timer, inventory registers and refill logic.

## Test plan
- **Full set:** refill 5 of each denomination, request 185 with immediate acks → ejects in order 100, 50, 20, 10, 5. `done` at cycle 17, `done_short`=0, each `inv_*`=4.
- **Greedy shortfall:** inv_50=1, inv_20=3, others 0; request 60 → ejects 50 only. `done_short`=1, `residual`=10, inv_20 still 3.
- **Hopper timeout:**
  - Setup: inv_100=2, request 100, `eject_ack` never asserted.
  - After 15 WAIT_ACK cycles → `hopper_fault`[4]=1, inv_100=2, `done_short`=1, `residual`=100.
  - Follow-up: refill denomination 4 with qty 0 clears the fault.
- **Non-multiple of 5:** inv_5=3, request 7 → one 5-coin ejected, `done_short`=1, `residual`=2.
- **Async reset mid-WAIT_ACK:** assert `rst` low → `eject`=0, state IDLE, `req_ready`=1, all `inv_*`=0, no `done` pulse.
- **Saturation and refill gating:**
  - CNT_W=6, inv_10=60, refill denomination 1 with qty 10 → inv_10=63.
  - A refill issued during EJECT is ignored.
